// File: rtl/rvfi_nret_packer.sv
// Packs a one-per-cycle RVFI retirement stream into NRET-lane groups, flushing early on trap, halt or idle timeout.
// Optional build macro RVFI_PACKER_ORDER_CHECK_EN adds a sticky order-sequence checker.
module rvfi_nret_packer #(
  parameter int NRET          = 2,
  parameter int XLEN          = 32,
  parameter int ILEN          = 32,
  parameter int FLUSH_TIMEOUT = 4,
  parameter int PKT_W         = 64 + ILEN + 3 + 2 + 2 + 5 + 5 + 2*XLEN + 5 + XLEN
                                + 2*XLEN + XLEN + 2*(XLEN/8) + 2*XLEN
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [PKT_W-1:0]        in_pkt,
  output logic [NRET-1:0]         out_valid,
  output logic [NRET*PKT_W-1:0]   out_pkt,
  output logic                    halted,
  output logic                    order_err
);

  localparam int ORD_LSB  = PKT_W - 64;
  localparam int TRAP_BIT = PKT_W - 65 - ILEN;
  localparam int HALT_BIT = TRAP_BIT - 1;
  localparam int FILL_W   = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int IDLE_W   = $clog2(FLUSH_TIMEOUT + 1);

  typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_HALTED} state_t;

  state_t              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [PKT_W-1:0]    lane_q [NRET];
  logic [PKT_W-1:0]    lane_d [NRET];
  logic [NRET-1:0]     out_valid_q, out_valid_d;
  logic [NRET*PKT_W-1:0] out_pkt_q, out_pkt_d;

  logic                accept;
  logic                is_event;
  logic                flush;
  logic [FILL_W:0]     flush_n;

  assign accept   = in_valid && (state_q != S_HALTED);
  assign is_event = in_pkt[TRAP_BIT] || in_pkt[HALT_BIT];

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    idle_d      = idle_q;
    lane_d      = lane_q;
    out_valid_d = '0;
    out_pkt_d   = '0;
    flush       = 1'b0;
    flush_n     = '0;

    if (accept) begin
      lane_d[fill_q] = in_pkt;
      idle_d         = '0;
      if (fill_q == FILL_W'(NRET - 1) || is_event) begin
        flush   = 1'b1;
        flush_n = {1'b0, fill_q} + 1'b1;
        fill_d  = '0;
        state_d = in_pkt[HALT_BIT] ? S_HALTED : S_EMPTY;
      end else begin
        fill_d  = fill_q + 1'b1;
        state_d = S_FILLING;
      end
    end else if (state_q == S_FILLING) begin
      // idle_q counts completed idle cycles, so the FLUSH_TIMEOUT-th idle cycle flushes
      if (idle_q == IDLE_W'(FLUSH_TIMEOUT - 1)) begin
        flush   = 1'b1;
        flush_n = {1'b0, fill_q};
        fill_d  = '0;
        idle_d  = '0;
        state_d = S_EMPTY;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    if (flush) begin
      for (int i = 0; i < NRET; i++) begin
        if (i < int'(flush_n)) begin
          out_valid_d[i]               = 1'b1;
          out_pkt_d[i*PKT_W +: PKT_W]  = lane_d[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      fill_q      <= '0;
      idle_q      <= '0;
      out_valid_q <= '0;
      out_pkt_q   <= '0;
      for (int i = 0; i < NRET; i++) lane_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      idle_q      <= idle_d;
      out_valid_q <= out_valid_d;
      out_pkt_q   <= out_pkt_d;
      for (int i = 0; i < NRET; i++) lane_q[i] <= lane_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_pkt   = out_pkt_q;
  assign halted    = (state_q == S_HALTED);

`ifdef RVFI_PACKER_ORDER_CHECK_EN
  logic [63:0] exp_order_q, exp_order_d;
  logic        order_err_q, order_err_d;

  // Resync to the observed order after every accept so one gap flags only once
  always_comb begin
    exp_order_d = exp_order_q;
    order_err_d = order_err_q;
    if (accept) begin
      if (in_pkt[ORD_LSB +: 64] != exp_order_q) order_err_d = 1'b1;
      exp_order_d = in_pkt[ORD_LSB +: 64] + 64'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      exp_order_q <= '0;
      order_err_q <= 1'b0;
    end else begin
      exp_order_q <= exp_order_d;
      order_err_q <= order_err_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_nret_packer.sv
// Scoreboard bench for rvfi_nret_packer: directed scenarios followed by random retirement traffic.
module tb_rvfi_nret_packer;

  localparam int NRET = 2;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int FT   = 4;
  localparam int PKT_W = 64 + ILEN + 3 + 2 + 2 + 5 + 5 + 2*XLEN + 5 + XLEN
                         + 2*XLEN + XLEN + 2*(XLEN/8) + 2*XLEN;
  localparam int ORD_LSB = PKT_W - 64;
  localparam int TRAP_B  = PKT_W - 65 - ILEN;
  localparam int HALT_B  = TRAP_B - 1;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic [PKT_W-1:0]      in_pkt;
  logic [NRET-1:0]       out_valid;
  logic [NRET*PKT_W-1:0] out_pkt;
  logic                  halted;
  logic                  order_err;

  rvfi_nret_packer #(.NRET(NRET), .XLEN(XLEN), .ILEN(ILEN), .FLUSH_TIMEOUT(FT)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_pkt(in_pkt),
    .out_valid(out_valid), .out_pkt(out_pkt), .halted(halted), .order_err(order_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int                    due;
    logic [NRET-1:0]       mask;
    logic [NRET*PKT_W-1:0] pkts;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  // Reference model: a queue of retired-but-unreported packets and a count of idle cycles since the last retire
  logic [PKT_W-1:0] pend[$];
  int          idle_m = 0;
  bit          halted_m = 0, halted_vis = 0;
  bit          err_m = 0, err_vis = 0;
  logic [63:0] exp_ord_m = 0;
  logic [63:0] ord_next = 0;

  function automatic void emit(int due);
    exp_t e;
    e.due  = due;
    e.mask = '0;
    e.pkts = '0;
    for (int i = 0; i < pend.size(); i++) begin
      e.mask[i] = 1'b1;
      e.pkts[i*PKT_W +: PKT_W] = pend[i];
    end
    exp_q.push_back(e);
    pend.delete();
  endfunction

  function automatic void model_step(bit v, logic [PKT_W-1:0] p, bit r, int t);
    if (r) begin
      pend.delete();
      idle_m = 0;
      halted_m = 0;
      err_m = 0;
      exp_ord_m = 0;
      return;
    end
    if (halted_m) return;
    if (v) begin
`ifdef RVFI_PACKER_ORDER_CHECK_EN
      if (p[ORD_LSB +: 64] != exp_ord_m) err_m = 1;
      exp_ord_m = p[ORD_LSB +: 64] + 64'd1;
`endif
      pend.push_back(p);
      idle_m = 0;
      if (pend.size() == NRET || p[TRAP_B] || p[HALT_B]) begin
        emit(t + 1);
        if (p[HALT_B]) halted_m = 1;
      end
    end else if (pend.size() != 0) begin
      idle_m++;
      if (idle_m == FT) begin
        emit(t + 1);
        idle_m = 0;
      end
    end
  endfunction

  function automatic logic [PKT_W-1:0] mk(logic [63:0] ord, bit trap, bit halt);
    logic [PKT_W-1:0] p;
    for (int i = 0; i < PKT_W; i++) p[i] = 1'($urandom_range(0, 1));
    p[ORD_LSB +: 64] = ord;
    p[TRAP_B] = trap;
    p[HALT_B] = halt;
    return p;
  endfunction

  task automatic drive(bit v, logic [PKT_W-1:0] p, bit r);
    @(posedge clock);
    #1;
    halted_vis = halted_m;
    err_vis    = err_m;
    reset    = r;
    in_valid = v;
    in_pkt   = p;
    model_step(v, p, r, cyc);
    if (r) ord_next = 0;
  endtask

  task automatic send_o(logic [63:0] ord, bit trap, bit halt);
    drive(1, mk(ord, trap, halt), 0);
    ord_next = ord + 64'd1;
  endtask

  task automatic send(bit trap, bit halt);
    send_o(ord_next, trap, halt);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0);
  endtask

  task automatic do_reset();
    drive(0, '0, 1);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (out_valid !== '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_group cyc=%0d out_valid=%b required no output", cyc, out_valid);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cyc != e.due || out_valid !== e.mask || out_pkt !== e.pkts) begin
            errors++;
            $display("FAIL group cyc=%0d required_cyc=%0d out_valid=%b required=%b lane0_order=%0d required=%0d",
                     cyc, e.due, out_valid, e.mask, out_pkt[ORD_LSB +: 64], e.pkts[ORD_LSB +: 64]);
          end else begin
            $display("group cyc=%0d mask=%b lane0_order=%0d", cyc, out_valid, out_pkt[ORD_LSB +: 64]);
          end
        end
      end else begin
        checks++;
        if (out_pkt !== '0) begin
          errors++;
          $display("FAIL idle_pkt_zero cyc=%0d out_pkt_nonzero=%b required 0", cyc, |out_pkt);
        end
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_group cyc=%0d out_valid=%b required=%b at cyc %0d", cyc, out_valid, e.mask, e.due);
        end
      end
      checks++;
      if (halted !== halted_vis) begin
        errors++;
        $display("FAIL halted cyc=%0d got=%b required=%b", cyc, halted, halted_vis);
      end
      checks++;
      if (order_err !== err_vis) begin
        errors++;
        $display("FAIL order_err cyc=%0d got=%b required=%b", cyc, order_err, err_vis);
      end
    end
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_pkt = '0;
    do_reset();
    do_reset();
    mon_en = 1;

    // Back-to-back pair fills a group
    idle(3);
    send(0, 0); send(0, 0);
    idle(3);
    // Single packet emitted by timeout
    send(0, 0);
    idle(8);
    // Trap flushes a partial group, next packet starts a fresh group
    send(1, 0);
    send(0, 0); send(1, 0);
    send(0, 0); send(0, 0);
    idle(2);
    // Accept arriving on the would-be timeout cycle joins the group
    send(0, 0); idle(FT - 1); send(0, 0);
    idle(2);
    send(0, 0); idle(FT - 1); send(1, 0);
    idle(2);
    // Halt then ignored traffic then reset
    send(0, 0); send(0, 1);
    send(0, 0); send(0, 0); idle(2); send(0, 0);
    idle(3);
    do_reset();
    idle(2);
    // Order gap detection and resync
    send_o(0, 0, 0); send_o(1, 0, 0); send_o(3, 0, 0); send_o(4, 0, 0);
    idle(6);
    // Reset with one packet buffered discards it
    do_reset();
    send(0, 0);
    do_reset();
    send(0, 0); send(0, 0);
    idle(3);

    for (int n = 0; n < 3000; n++) begin
      if ((halted_m && $urandom_range(0, 5) == 0) || $urandom_range(0, 149) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 99) < 60) begin
        logic [63:0] o;
        o = ord_next;
        if ($urandom_range(0, 39) == 0) o = o + 64'd1;
        send_o(o, $urandom_range(0, 15) == 0, $urandom_range(0, 59) == 0);
      end else begin
        idle($urandom_range(1, FT + 1));
      end
    end

    idle(FT + 4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending_groups=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
